// File: rtl/can_bus_pkg.sv
// Shared types and constants for the CAN CPU bus cycle controller.
package can_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_ACK,
        ST_REARM
    } bus_state_e;

    localparam logic [4:0] ADDR_INTREG = 5'h12;
    localparam logic [4:0] ADDR_SYSID  = 5'h14;
    localparam int         NUM_WR_REGS = 20;
    localparam int         WAIT_W      = 3;

endpackage

// File: rtl/can_cpu_bus_ctrl_if.sv
// CPU-side and register-file-side bus signals of the CAN bus cycle controller.
interface can_cpu_bus_ctrl_if;
    import can_bus_pkg::*;

    logic                   cpu_cs;
    logic                   cpu_rd;
    logic                   cpu_wr;
    logic [4:0]             cpu_addr;
    logic [15:0]            cpu_wdata;
    logic [15:0]            cpu_rdata;
    logic                   cpu_ack;
    logic [4:0]             mux_address;
    logic [15:0]            mux_data;
    logic [NUM_WR_REGS-1:0] reg_wr_en;
    logic [15:0]            reg_wdata;
    logic                   int_clr;

    modport slave (
        input  cpu_cs, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mux_data,
        output cpu_rdata, cpu_ack, mux_address, reg_wr_en, reg_wdata, int_clr
    );

    modport master (
        output cpu_cs, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mux_data,
        input  cpu_rdata, cpu_ack, mux_address, reg_wr_en, reg_wdata, int_clr
    );

endinterface

// File: rtl/can_wr_decode.sv
// Address to one-hot register write enable; all-zero at and above the HW-ID address.
module can_wr_decode
    import can_bus_pkg::*;
(
    input  logic                   en,
    input  logic [4:0]             addr,
    output logic [NUM_WR_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && (addr < ADDR_SYSID)) begin
            onehot = NUM_WR_REGS'(1) << addr;
        end
    end

endmodule

// File: rtl/can_cpu_bus_ctrl.sv
// CPU bus cycle controller for the CAN register file.
// Optional read-clear of the interrupt register: define CAN_INT_CLR_ON_READ_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a valid read or write request
// ST_WAIT  | wait states, counting down on the latched request
// ST_XFER  | capture read data / issue write enable at the closing edge
// ST_ACK   | ack held until chip select drops
// ST_REARM | select held through reset; wait for it to drop
module can_cpu_bus_ctrl
    import can_bus_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic         clock,
    input  logic         reset,
    can_cpu_bus_ctrl_if.slave bus
);

    localparam logic [WAIT_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : WAIT_W'(WAIT_STATES - 1);

    bus_state_e             state_q, state_d;
    logic [WAIT_W-1:0]      cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic [4:0]             addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic [NUM_WR_REGS-1:0] wr_en_q, wr_en_d;
    logic                   int_clr_q, int_clr_d;
    logic [NUM_WR_REGS-1:0] dec_onehot;

    can_wr_decode u_wr_decode (
        .en     (dir_q),
        .addr   (addr_q),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= bus.cpu_cs ? ST_REARM : ST_IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            wr_en_q   <= '0;
            int_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            int_clr_q <= int_clr_d;
        end
    end

    // Enable and read-clear default to zero, so they are single-cycle pulses out of XFER.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        wr_en_d   = '0;
        int_clr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_cs && (bus.cpu_rd ^ bus.cpu_wr)) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    dir_d   = bus.cpu_wr;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_STATES == 0) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_XFER: begin
                ack_d   = 1'b1;
                wr_en_d = dec_onehot;
                if (!dir_q) begin
                    rdata_d = bus.mux_data;
                end
`ifdef CAN_INT_CLR_ON_READ_EN
                int_clr_d = !dir_q && (addr_q == ADDR_INTREG);
`else
                int_clr_d = 1'b0;
`endif
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!bus.cpu_cs) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_REARM: begin
                if (!bus.cpu_cs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mux_address = addr_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_ack     = ack_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.int_clr     = int_clr_q;

endmodule

// File: tb/tb_can_cpu_bus_ctrl.sv
// Directed, table-driven bench for can_cpu_bus_ctrl with WAIT_STATES=1.
module tb_can_cpu_bus_ctrl;

    localparam int WS = 1;
`ifdef CAN_INT_CLR_ON_READ_EN
    localparam logic INT_CLR_EN = 1'b1;
`else
    localparam logic INT_CLR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    can_cpu_bus_ctrl_if bus ();

    can_cpu_bus_ctrl #(.WAIT_STATES(WS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Register-file read mux stand-in: 0x0E holds 16'h1234, others 16'hC000 | addr.
    always_comb begin
        if (bus.mux_address == 5'h0E) bus.mux_data = 16'h1234;
        else                          bus.mux_data = {11'b1100_0000_000, bus.mux_address};
    end

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [19:0] exp_wr_en;
        logic        exp_int_clr;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic rd, input logic wr,
                         input logic [4:0] addr, input logic [15:0] wdata);
        bus.cpu_cs    = cs;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    // Runs one transfer; optionally scrambles address/data during the wait state.
    task automatic run_xfer(input string tag, input vec_t v, input logic scramble);
        int   n;
        logic early_pulse;
        drive(1'b1, !v.wr, v.wr, v.addr, v.wdata);
        n = 0;
        early_pulse = 1'b0;
        do begin
            tick();
            n++;
            if (n == 1 && scramble) begin
                bus.cpu_addr  = ~v.addr;
                bus.cpu_wdata = ~v.wdata;
            end
            if (!bus.cpu_ack && (bus.reg_wr_en != '0 || bus.int_clr)) early_pulse = 1'b1;
        end while (!bus.cpu_ack && n < 20);
        check({tag, "_ack_latency"}, n, WS + 2);
        check({tag, "_early_pulse"}, early_pulse, 0);
        check({tag, "_mux_address"}, bus.mux_address, v.addr);
        check({tag, "_wr_en"}, bus.reg_wr_en, v.exp_wr_en);
        check({tag, "_int_clr"}, bus.int_clr, v.exp_int_clr);
        if (v.wr) check({tag, "_wdata"}, bus.reg_wdata, v.wdata);
        else      check({tag, "_rdata"}, bus.cpu_rdata, v.exp_rdata);
        tick();
        check({tag, "_ack_hold"}, bus.cpu_ack, 1);
        check({tag, "_pulse_end"}, {bus.reg_wr_en, bus.int_clr}, 0);
        if (!v.wr) check({tag, "_rdata_hold"}, bus.cpu_rdata, v.exp_rdata);
        bus.cpu_cs = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        tick();
        check({tag, "_ack_fall"}, bus.cpu_ack, 0);
    endtask

    initial begin
        vec_t v;
        logic seen_ack;
        logic seen_wr;

        vecs[0] = '{1'b0, 5'h0E, 16'h0000, 16'h1234, 20'h00000, 1'b0};
        vecs[1] = '{1'b1, 5'h05, 16'hBEEF, 16'h0000, 20'h00020, 1'b0};
        vecs[2] = '{1'b1, 5'h14, 16'h0A0A, 16'h0000, 20'h00000, 1'b0};
        vecs[3] = '{1'b1, 5'h1F, 16'h5151, 16'h0000, 20'h00000, 1'b0};
        vecs[4] = '{1'b0, 5'h12, 16'h0000, 16'hC012, 20'h00000, INT_CLR_EN};
        vecs[5] = '{1'b0, 5'h11, 16'h0000, 16'hC011, 20'h00000, 1'b0};
        vecs[6] = '{1'b1, 5'h13, 16'h55AA, 16'h0000, 20'h80000, 1'b0};
        vecs[7] = '{1'b1, 5'h00, 16'h0F0F, 16'h0000, 20'h00001, 1'b0};

        drive(1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
        tick();
        tick();
        check("reset_outputs",
              {bus.cpu_rdata, bus.cpu_ack, bus.mux_address, bus.reg_wr_en, bus.reg_wdata, bus.int_clr},
              0);
        check("reset_outputs_hi", {bus.reg_wr_en[19:4]}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_xfer($sformatf("v%0d", i), vecs[i], 1'b0);
        end

        // Both strobes high is not a request.
        drive(1'b1, 1'b1, 1'b1, 5'h05, 16'hFFFF);
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cpu_ack || bus.reg_wr_en != '0) seen_ack = 1'b1;
        end
        check("rd_wr_both_no_ack", seen_ack, 0);
        drive(1'b1, 1'b0, 1'b0, 5'h05, 16'hFFFF);
        seen_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.cpu_ack) seen_ack = 1'b1;
        end
        check("no_strobe_no_ack", seen_ack, 0);
        drive(1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
        tick();

        // Address/data changed during the wait state must not affect the transfer.
        v = '{1'b0, 5'h0E, 16'h0000, 16'h1234, 20'h00000, 1'b0};
        run_xfer("latch_rd", v, 1'b1);
        v = '{1'b1, 5'h02, 16'h1111, 16'h0000, 20'h00004, 1'b0};
        run_xfer("latch_wr", v, 1'b1);

        // Reset during the wait state of a write with select held.
        drive(1'b1, 1'b0, 1'b1, 5'h03, 16'hCAFE);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_outputs",
              {bus.cpu_rdata, bus.cpu_ack, bus.mux_address, bus.reg_wdata, bus.int_clr}, 0);
        check("midrst_wr_en", bus.reg_wr_en, 0);
        reset = 1'b0;
        seen_ack = 1'b0;
        seen_wr  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cpu_ack) seen_ack = 1'b1;
            if (bus.reg_wr_en != '0) seen_wr = 1'b1;
        end
        check("rearm_no_ack", seen_ack, 0);
        check("rearm_no_wr_en", seen_wr, 0);
        drive(1'b0, 1'b0, 1'b0, 5'h03, 16'hCAFE);
        tick();
        v = '{1'b1, 5'h03, 16'hCAFE, 16'h0000, 20'h00008, 1'b0};
        run_xfer("after_rearm", v, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_cpu_bus_ctrl.md
# can_cpu_bus_ctrl

CPU bus cycle controller for the CAN controller register file. Sits directly upstream of the read multiplexer. It samples CPU read/write requests, drives the multiplexer address from a latched copy, and captures the multiplexer output into a stable read-data register. For writes it emits a one-cycle one-hot register write enable, then acknowledges with a four-phase handshake.

## Interface
Parameters:
- WAIT_STATES, default 1: cycles inserted between request sample and transfer; legal 0..7.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_cs  in  1  chip select; high for the whole CPU cycle.
- cpu_rd  in  1  read strobe, qualified by cpu_cs.
- cpu_wr  in  1  write strobe, qualified by cpu_cs.
- cpu_addr  in  5  register address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  registered read data; valid while cpu_ack=1 after a read.
- cpu_ack  out  1  transfer acknowledge.
- mux_address  out  5  latched address to the read multiplexer.
- mux_data  in  16  read multiplexer output (combinational from mux_address).
- reg_wr_en  out  20  one-hot write enable for addresses 0x00..0x13.
- reg_wdata  out  16  latched write data; valid while any reg_wr_en bit is high.
- int_clr  out  1  interrupt-register read-clear pulse (see Configuration).

## Operation
- States: IDLE, WAIT, XFER, ACK, REARM.
- IDLE, request valid (cpu_cs=1 and exactly one of cpu_rd/cpu_wr):
  - Latch cpu_addr into mux_address, cpu_wdata into reg_wdata, and the direction bit.
  - Next state is WAIT with counter=WAIT_STATES-1, or XFER when WAIT_STATES=0.
- cpu_cs=1 with both rd and wr high, or neither: not a request; stay in IDLE, no ack.
- WAIT: decrement the counter; go to XFER when the counter is 0. Address and data inputs are ignored; the latched values are used.
- XFER (one cycle); at its closing edge:
  - cpu_ack<=1.
  - Read: cpu_rdata<=mux_data.
  - Write with latched address < 20: reg_wr_en<=one-hot(address).
  - Write with address >= 20 (HW-ID and unmapped): no enable, still acked.
  - Next state is ACK.
- ACK: reg_wr_en<=0 and int_clr<=0, so both are one-cycle pulses. Hold cpu_ack=1 and cpu_rdata until cpu_cs=0. At the edge where cpu_cs=0 is seen: cpu_ack<=0 and go to IDLE.
- REARM: entered only from reset while cpu_cs=1. Wait for cpu_cs=0, then IDLE. A select held through reset never starts a transfer.
- Counter width is 3 bits and never wraps below 0.
- Reset values: cpu_rdata=0, cpu_ack=0, mux_address=0, reg_wr_en=0, reg_wdata=0, int_clr=0.
- Reset state: IDLE, or REARM if cpu_cs=1 at the reset edge.
- Reset mid-transfer: the transfer is abandoned and no write enable is issued.

## Timing
- A request sampled at edge e0 produces cpu_ack high after edge e(WAIT_STATES+1).
- reg_wr_en and int_clr are high exactly during the first cycle of cpu_ack.
- cpu_ack falls one edge after cpu_cs is sampled low.
- Minimum cpu_cs low time between transfers: 1 cycle. Back-to-back requests need cpu_cs deasserted for that cycle.
- cpu_rdata is registered, so there is no combinational path from mux_data to the CPU.

## Configuration
- CAN_INT_CLR_ON_READ_EN defined: a read of address 0x12 (interrupt register) sets int_clr<=1 at the XFER edge; int_clr is cleared in the next cycle.
- Not defined: int_clr is constant 0 and the port remains present.

## Structure
- Shared package can_bus_pkg holds:
  - the state enum;
  - ADDR_INTREG=5'h12, ADDR_SYSID=5'h14;
  - NUM_WR_REGS=20;
  - WAIT_W=3.
- One sub-module: can_wr_decode, a combinational 5-bit address to 20-bit one-hot decoder with an enable input; all-zero for address >= 20.

## Test plan
- WAIT_STATES=1, read 0x0E with mux_data=16'h1234 -> cpu_ack high after edge e2, cpu_rdata=16'h1234, ack falls one edge after cpu_cs drops.
- Write 0x05 with data 16'hBEEF -> reg_wr_en=20'h00020 for exactly 1 cycle coincident with the ack rise, reg_wdata=16'hBEEF.
- Write 0x14 and write 0x1F -> cpu_ack asserted, reg_wr_en stays 0.
- Read 0x12 -> int_clr pulses 1 cycle with CAN_INT_CLR_ON_READ_EN defined, stays 0 without it; read 0x11 -> int_clr never pulses.
- Assert reset during WAIT of a write to 0x03 while cpu_cs held -> all outputs 0, no reg_wr_en pulse, no ack until cpu_cs low then high again.
- cpu_rd and cpu_wr both high, then cpu_addr changed during WAIT -> first: no ack; second: capture uses the originally latched address.
